// File: rtl/swap_pkg.sv
// Shared definitions for the swap command sequencer.
//   cmd_op_e    : command opcode encodings carried on cmd_op
//   seq_state_e : sequencer FSM states
package swap_pkg;

  typedef enum logic [1:0] {
    OpWrite   = 2'b00,
    OpSwap    = 2'b01,
    OpNop     = 2'b10,
    OpIllegal = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWrite = 2'b01,
    StSwap  = 2'b10,
    StGap   = 2'b11
  } seq_state_e;

  // Width of one queued command: opcode, two addresses and write data.
  function automatic int unsigned cmd_width(input int unsigned mem_width,
                                            input int unsigned data_width);
    return 2 + 2 * mem_width + data_width;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for sequencer commands.
//   clk, reset_n : clock, asynchronous active-low reset (empties the queue)
//   push, wdata  : write request and data; ignored while full
//   full         : no free entry
//   pop          : advance read pointer; ignored while empty
//   rdata        : head entry, valid whenever empty is low
//   empty        : no stored entry
module cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AddrW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AddrW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/swap_cmd_seq.sv
// Command sequencer in front of a swap-capable register file.
// Commands are queued in cmd_fifo and replayed as registered write or swap strobes.
//   clk, reset_n             : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (cmd_ready = queue not full)
//   cmd_op                   : WRITE / SWAP / NOP / illegal
//   cmd_addr_a/_b, cmd_data  : command operands
//   we, address_w, data_w    : registered single-cycle write strobe and operands
//   swap, address_A/_B       : registered swap strobe (held SWAP_HOLD cycles) and operands
//   busy                     : queue non-empty or sequencer active
//   err                      : one-cycle pulse per dropped command
module swap_cmd_seq
  import swap_pkg::*;
#(
  parameter int unsigned mem_width  = 7,
  parameter int unsigned data_width = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SWAP_HOLD  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [mem_width-1:0]  cmd_addr_a,
  input  logic [mem_width-1:0]  cmd_addr_b,
  input  logic [data_width-1:0] cmd_data,
  output logic                  we,
  output logic [mem_width-1:0]  address_w,
  output logic [data_width-1:0] data_w,
  output logic                  swap,
  output logic [mem_width-1:0]  address_A,
  output logic [mem_width-1:0]  address_B,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CmdW = cmd_width(mem_width, data_width);
  // The counter only has to reach SWAP_HOLD-1.
  localparam int unsigned CntW = (SWAP_HOLD > 1) ? $clog2(SWAP_HOLD) : 1;

  // Command queue
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CmdW-1:0] fifo_wdata, fifo_rdata;

  assign fifo_wdata = {cmd_op, cmd_addr_a, cmd_addr_b, cmd_data};

  cmd_fifo #(
    .Width (CmdW),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .wdata   (fifo_wdata),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty)
  );

  cmd_op_e               head_op;
  logic [mem_width-1:0]  head_addr_a, head_addr_b;
  logic [data_width-1:0] head_data;

  assign head_op     = cmd_op_e'(fifo_rdata[CmdW-1 -: 2]);
  assign head_addr_a = fifo_rdata[data_width + mem_width +: mem_width];
  assign head_addr_b = fifo_rdata[data_width +: mem_width];
  assign head_data   = fifo_rdata[data_width-1:0];

  // Sequencer state and output registers
  seq_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  swap_q, swap_d;
  logic                  err_q, err_d;
  logic [mem_width-1:0]  address_w_q, address_w_d;
  logic [data_width-1:0] data_w_q, data_w_d;
  logic [mem_width-1:0]  address_a_q, address_a_d;
  logic [mem_width-1:0]  address_b_q, address_b_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    swap_d      = 1'b0;
    err_d       = 1'b0;
    address_w_d = address_w_q;
    data_w_d    = data_w_q;
    address_a_d = address_a_q;
    address_b_d = address_b_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      StSwap: begin
        if (cnt_q == '0) begin
          state_d = StGap;
        end else begin
          cnt_d  = cnt_q - CntW'(1);
          swap_d = 1'b1;
        end
      end

      // The edge that closes a WRITE or GAP cycle may already take the next
      // command, so back-to-back writes stream at one per cycle and a
      // queued command follows a swap directly after its single gap cycle.
      StIdle, StWrite, StGap: begin
        state_d = StIdle;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          unique case (head_op)
            OpWrite: begin
              state_d     = StWrite;
              we_d        = 1'b1;
              address_w_d = head_addr_a;
              data_w_d    = head_data;
            end
            OpSwap: begin
              if (head_addr_a != head_addr_b) begin
                state_d     = StSwap;
                swap_d      = 1'b1;
                cnt_d       = CntW'(SWAP_HOLD - 1);
                address_a_d = head_addr_a;
                address_b_d = head_addr_b;
              end else begin
                // Self-swap is meaningless; drop it and flag.
                err_d = 1'b1;
              end
            end
            OpNop:     ;
            OpIllegal: err_d = 1'b1;
          endcase
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
      address_w_q <= '0;
      data_w_q    <= '0;
      address_a_q <= '0;
      address_b_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
      address_w_q <= address_w_d;
      data_w_q    <= data_w_d;
      address_a_q <= address_a_d;
      address_b_q <= address_b_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != StIdle);
  assign we        = we_q;
  assign swap      = swap_q;
  assign err       = err_q;
  assign address_w = address_w_q;
  assign data_w    = data_w_q;
  assign address_A = address_a_q;
  assign address_B = address_b_q;

endmodule

// File: tb/tb_swap_cmd_seq.sv
// Self-checking bench for swap_cmd_seq. A transaction-level model turns each
// accepted command into the register-file operation it must produce; a monitor
// collects the operations the DUT actually performs and watches hold/overlap rules.
module tb_swap_cmd_seq;

  localparam int unsigned MemW  = 7;
  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned Hold  = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [MemW-1:0]  cmd_addr_a, cmd_addr_b;
  logic [DataW-1:0] cmd_data;
  logic             we, swap, busy, err;
  logic [MemW-1:0]  address_w, address_A, address_B;
  logic [DataW-1:0] data_w;

  always #5 clk = ~clk;

  swap_cmd_seq #(
    .mem_width  (MemW),
    .data_width (DataW),
    .FIFO_DEPTH (Depth),
    .SWAP_HOLD  (Hold)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_data   (cmd_data),
    .we         (we),
    .address_w  (address_w),
    .data_w     (data_w),
    .swap       (swap),
    .address_A  (address_A),
    .address_B  (address_B),
    .busy       (busy),
    .err        (err)
  );

  // Register-file operation: kind 0 write(a=addr, b=data), 1 swap(a, b, len cycles), 2 error.
  typedef struct packed {
    int kind;
    int a;
    int b;
    int len;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t cur_swap;

  int n_checks = 0;
  int n_errors = 0;
  int accepted, started, viol_proto, viol_hold, viol_ready;
  int cyc = 0;
  int we_run = 0;
  int max_we_run, swap_rise_cyc, we_after_swap, first_low_acc;
  bit mon_en = 1'b0;
  bit ready_chk = 1'b0;
  bit timeout;
  logic             swap_prev;
  logic [MemW-1:0]  last_aw, last_a, last_b;
  logic [DataW-1:0] last_dw;

  // Reference model: what one accepted command must do to the register file.
  task automatic model_cmd(input logic [1:0] op, input int a, input int b, input int d);
    ev_t e;
    e = '{kind: 2, a: 0, b: 0, len: 1};
    if (op == 2'b00) begin
      e = '{kind: 0, a: a, b: d, len: 1};
      exp_q.push_back(e);
    end else if (op == 2'b01 && a != b) begin
      e = '{kind: 1, a: a, b: b, len: int'(Hold)};
      exp_q.push_back(e);
    end else if (op != 2'b10) begin
      exp_q.push_back(e);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (!reset_n) begin
      swap_prev = 1'b0;
      last_aw = '0; last_dw = '0; last_a = '0; last_b = '0;
      we_run = 0;
    end else if (mon_en) begin
      if (we && swap) viol_proto++;
      if (we) begin
        e = '{kind: 0, a: int'(address_w), b: int'(data_w), len: 1};
        obs_q.push_back(e);
        started++;
        last_aw = address_w;
        last_dw = data_w;
        we_run++;
        if (we_run > max_we_run) max_we_run = we_run;
        if (swap_rise_cyc >= 0 && we_after_swap < 0) we_after_swap = cyc;
      end else begin
        we_run = 0;
        if (address_w !== last_aw || data_w !== last_dw) viol_hold++;
      end
      if (swap) begin
        if (!swap_prev) begin
          cur_swap = '{kind: 1, a: int'(address_A), b: int'(address_B), len: 1};
          started++;
          swap_rise_cyc = cyc;
          we_after_swap = -1;
        end else begin
          cur_swap.len++;
          if (int'(address_A) != cur_swap.a || int'(address_B) != cur_swap.b) viol_hold++;
        end
        last_a = address_A;
        last_b = address_B;
      end else begin
        if (swap_prev) obs_q.push_back(cur_swap);
        if (address_A !== last_a || address_B !== last_b) viol_hold++;
      end
      swap_prev = swap;
      if (err) begin
        e = '{kind: 2, a: 0, b: 0, len: 1};
        obs_q.push_back(e);
        started++;
      end
      if (!cmd_ready && first_low_acc < 0) first_low_acc = accepted;
      // Commands accepted but not yet started must equal queue occupancy.
      if (ready_chk && (cmd_ready !== ((accepted - started) < int'(Depth)))) viol_ready++;
    end
  end

  task automatic clear_stats();
    exp_q.delete();
    obs_q.delete();
    accepted = 0; started = 0;
    viol_proto = 0; viol_hold = 0; viol_ready = 0;
    max_we_run = 0; swap_rise_cyc = -1; we_after_swap = -1; first_low_acc = -1;
  endtask

  // Offer one command and hold it until accepted. Called just after a rising edge.
  task automatic send(input logic [1:0] op, input int a, input int b, input int d);
    int   waited = 0;
    logic rdy;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = MemW'(a);
    cmd_addr_b = MemW'(b);
    cmd_data   = DataW'(d);
    forever begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        accepted++;
        model_cmd(op, a, b, d);
        break;
      end
      waited++;
      if (waited > 200) break;
    end
    n_checks++;
    if (waited > 200) begin
      n_errors++;
      $display("FAIL send_accept cmd_ready got 0 want 1 within 200 cycles");
    end
    #1 cmd_valid = 1'b0;
  endtask

  // Wait for the sequencer to go quiet (bounded), then let the monitor settle.
  task automatic drain();
    int n = 0;
    timeout = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || we || swap) && n < 300);
    if (n >= 300) timeout = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready got %b want 1", cmd_ready);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if ({we, swap, err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_strobes got %b want 000", {we, swap, err});
    end
    n_checks++;
    if ({address_w, data_w, address_A, address_B} !== '0) begin
      n_errors++;
      $display("FAIL reset_operands got aw=%0h dw=%0h A=%0h B=%0h want 0",
               address_w, data_w, address_A, address_B);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    clear_stats();
    ready_chk = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr_a = 7'd5; cmd_addr_b = '0; cmd_data = 8'h33;
    @(posedge clk);
    accepted++;
    model_cmd(2'b00, 5, 0, 8'h33);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we !== 1'b0) begin
      n_errors++; $display("FAIL latency_early we got %b want 0", we);
    end
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || address_w !== 7'd5 || data_w !== 8'h33) begin
      n_errors++;
      $display("FAIL latency_write got we=%b aw=%0d dw=%0h want we=1 aw=5 dw=33",
               we, address_w, data_w);
    end
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size() || timeout) begin
      n_errors++;
      $display("FAIL latency_events got %0d ops want %0d (stuck=%b)",
               obs_q.size(), exp_q.size(), timeout);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    ready_chk = 1'b1;
    for (int i = 20; i < 30; i++) send(2'b00, i, 0, i);
    drain();
    n_checks++;
    if (max_we_run != 10) begin
      n_errors++; $display("FAIL b2b_we_run got %0d want 10", max_we_run);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size() || timeout) begin
      n_errors++;
      $display("FAIL b2b_count got %0d want %0d (stuck=%b)", obs_q.size(), exp_q.size(), timeout);
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL b2b_op[%0d] got k%0d a%0d b%0d n%0d want k%0d a%0d b%0d n%0d", i,
                 obs_q[i].kind, obs_q[i].a, obs_q[i].b, obs_q[i].len,
                 exp_q[i].kind, exp_q[i].a, exp_q[i].b, exp_q[i].len);
      end
    end
    n_checks++;
    if (viol_proto + viol_hold + viol_ready != 0) begin
      n_errors++;
      $display("FAIL b2b_rules got overlap=%0d hold=%0d ready=%0d want 0 0 0",
               viol_proto, viol_hold, viol_ready);
    end
  endtask

  task automatic test_swap();
    int n = 0;
    int hi = 0;
    clear_stats();
    ready_chk = 1'b1;
    send(2'b01, 22, 28, 0);
    do begin @(negedge clk); n++; end while (!swap && n < 10);
    while (swap && hi < 20) begin hi++; @(negedge clk); end
    n_checks++;
    if (hi != int'(Hold)) begin
      n_errors++; $display("FAIL swap_len got %0d want %0d", hi, Hold);
    end
    n_checks++;
    if (busy !== 1'b1 || we !== 1'b0) begin
      n_errors++; $display("FAIL swap_gap got busy=%b we=%b want busy=1 we=0", busy, we);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL swap_busy_fall got %b want 0", busy);
    end
    drain();
    n_checks++;
    if (obs_q.size() != 1 || obs_q.size() != exp_q.size() || timeout) begin
      n_errors++; $display("FAIL swap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else if (obs_q[0] !== exp_q[0]) begin
      n_errors++;
      $display("FAIL swap_op got a%0d b%0d n%0d want a%0d b%0d n%0d",
               obs_q[0].a, obs_q[0].b, obs_q[0].len, exp_q[0].a, exp_q[0].b, exp_q[0].len);
    end
  endtask

  task automatic test_swap_then_write();
    clear_stats();
    ready_chk = 1'b1;
    send(2'b01, 22, 28, 0);
    send(2'b00, 5, 0, 8'hAA);
    drain();
    n_checks++;
    if (swap_rise_cyc < 0 || we_after_swap - swap_rise_cyc != 4) begin
      n_errors++;
      $display("FAIL swap_write_gap got %0d cycles want 4", we_after_swap - swap_rise_cyc);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size() || timeout) begin
      n_errors++; $display("FAIL swap_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL swap_write_op[%0d] got k%0d a%0d b%0d n%0d want k%0d a%0d b%0d n%0d", i,
                 obs_q[i].kind, obs_q[i].a, obs_q[i].b, obs_q[i].len,
                 exp_q[i].kind, exp_q[i].a, exp_q[i].b, exp_q[i].len);
      end
    end
    n_checks++;
    if (viol_proto + viol_hold + viol_ready != 0) begin
      n_errors++;
      $display("FAIL swap_write_rules got overlap=%0d hold=%0d ready=%0d want 0 0 0",
               viol_proto, viol_hold, viol_ready);
    end
  endtask

  // A swap followed immediately by six more commands: the queue fills while swap runs.
  task automatic test_fill();
    clear_stats();
    ready_chk = 1'b1;
    send(2'b01, 22, 28, 0);
    send(2'b00, 40, 0, 8'h40);
    send(2'b01, 1, 2, 0);
    for (int i = 41; i < 45; i++) send(2'b00, i, 0, i + 8'h10);
    drain();
    n_checks++;
    if (first_low_acc - 1 != int'(Depth)) begin
      n_errors++;
      $display("FAIL fill_ready_low got %0d accepted want %0d", first_low_acc - 1, Depth);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size() || timeout) begin
      n_errors++; $display("FAIL fill_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL fill_op[%0d] got k%0d a%0d b%0d n%0d want k%0d a%0d b%0d n%0d", i,
                 obs_q[i].kind, obs_q[i].a, obs_q[i].b, obs_q[i].len,
                 exp_q[i].kind, exp_q[i].a, exp_q[i].b, exp_q[i].len);
      end
    end
    n_checks++;
    if (viol_proto + viol_hold + viol_ready != 0) begin
      n_errors++;
      $display("FAIL fill_rules got overlap=%0d hold=%0d ready=%0d want 0 0 0",
               viol_proto, viol_hold, viol_ready);
    end
  endtask

  task automatic test_drop();
    clear_stats();
    ready_chk = 1'b1;
    send(2'b01, 10, 10, 0);
    send(2'b11, 1, 2, 0);
    send(2'b00, 7, 0, 8'h5A);
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size() || timeout) begin
      n_errors++; $display("FAIL drop_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL drop_op[%0d] got k%0d a%0d b%0d want k%0d a%0d b%0d", i,
                 obs_q[i].kind, obs_q[i].a, obs_q[i].b, exp_q[i].kind, exp_q[i].a, exp_q[i].b);
      end
    end
  endtask

  task automatic test_random();
    int sel, a, b;
    clear_stats();
    ready_chk = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        send(2'b00, $urandom_range(0, 127), 0, $urandom_range(0, 255));
      end else if (sel <= 7) begin
        a = $urandom_range(0, 7);
        b = $urandom_range(0, 7);
        send(2'b01, a, b, 0);
      end else if (sel == 8) begin
        send(2'b10, $urandom_range(0, 127), $urandom_range(0, 127), 0);
      end else begin
        send(2'b11, $urandom_range(0, 127), $urandom_range(0, 127), 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size() || timeout) begin
      n_errors++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL random_op[%0d] got k%0d a%0d b%0d n%0d want k%0d a%0d b%0d n%0d", i,
                 obs_q[i].kind, obs_q[i].a, obs_q[i].b, obs_q[i].len,
                 exp_q[i].kind, exp_q[i].a, exp_q[i].b, exp_q[i].len);
      end
    end
    n_checks++;
    if (viol_proto + viol_hold != 0) begin
      n_errors++;
      $display("FAIL random_rules got overlap=%0d hold=%0d want 0 0", viol_proto, viol_hold);
    end
  endtask

  task automatic test_reset_mid_swap();
    int act = 0;
    clear_stats();
    mon_en = 1'b0;
    send(2'b01, 3, 4, 0);
    send(2'b00, 9, 0, 1);
    send(2'b00, 10, 0, 2);
    // Swap rose at the edge that accepted the first write; this is its second cycle.
    @(negedge clk);
    n_checks++;
    if (swap !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_pre swap got %b want 1", swap);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (swap !== 1'b0 || we !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_strobes got swap=%b we=%b want 0 0", swap, we);
    end
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_status got ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (we || swap || err || busy) act++;
    end
    n_checks++;
    if (act != 0) begin
      n_errors++; $display("FAIL rst_mid_flushed got %0d active cycles want 0", act);
    end
    @(posedge clk);
    #1;
    clear_stats();
    mon_en = 1'b1;
  endtask

  initial begin
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_data   = '0;
    clear_stats();
    test_reset();
    mon_en = 1'b1;
    test_latency();
    test_back_to_back();
    test_swap();
    test_swap_then_write();
    test_fill();
    test_drop();
    test_random();
    test_reset_mid_swap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/swap_cmd_seq.md
SWAP_CMD_SEQ -- requirements
Module: swap_cmd_seq

Interface
REQ-001 Parameter: mem_width, default 7, address width of the downstream swap register file.
REQ-002 Parameter: data_width, default 8, data width of the downstream swap register file.
REQ-003 Parameter: FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-004 Parameter: SWAP_HOLD, default 3, cycles swap is held high per swap command (>=1).
REQ-005 Port: clk  in  1  single clock; all logic on rising edge.
REQ-006 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: cmd_valid  in  1  command offered.
REQ-008 Port: cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-009 Port: cmd_op  in  2  2'b00 WRITE, 2'b01 SWAP, 2'b10 NOP, 2'b11 illegal.
REQ-010 Port: cmd_addr_a  in  mem_width  write address (WRITE) or first swap address (SWAP).
REQ-011 Port: cmd_addr_b  in  mem_width  second swap address (SWAP only).
REQ-012 Port: cmd_data  in  data_width  write data (WRITE only).
REQ-013 Ports to register file, all registered outputs: we (1), address_w (mem_width), data_w (data_width), swap (1), address_A (mem_width), address_B (mem_width).
REQ-014 Port: busy  out  1  high when FIFO non-empty or FSM not IDLE.
REQ-015 Port: err  out  1  one-cycle pulse on a dropped command.

Function
REQ-016 cmd_ready SHALL equal !fifo_full; the FIFO SHALL accept one command per cycle.
REQ-017 FSM states SHALL be IDLE, WRITE, SWAP, GAP.
REQ-018 IDLE with FIFO non-empty: the FSM SHALL pop the head at the next edge and decode it.
REQ-019 Popped WRITE: we=1, address_w=cmd_addr_a, data_w=cmd_data for exactly one cycle (state WRITE); the next pop SHALL occur at the same edge that ends WRITE, giving one write per cycle for back-to-back WRITEs.
REQ-020 Popped SWAP with addr_a != addr_b: swap=1, address_A=addr_a, address_B=addr_b held exactly SWAP_HOLD cycles (state SWAP, down-counter), then one GAP cycle with swap=0, then IDLE.
REQ-021 we and swap SHALL never be high in the same cycle; no pop SHALL occur during SWAP or GAP.
REQ-022 Popped SWAP with addr_a == addr_b or illegal op: command dropped, err=1 for one cycle, FSM stays IDLE.
REQ-023 Popped NOP: consumed in one cycle, no output activity, no err.
REQ-024 Latency: command accepted at edge N into empty FIFO with FSM IDLE -> register-file outputs active in the cycle after edge N+1.
REQ-025 address_A/address_B/address_w/data_w SHALL hold last driven values when their strobes are low.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits; wrap-around by natural overflow; full when MSBs differ and LSBs equal.

Reset
REQ-027 reset_n low SHALL asynchronously clear: we=0, swap=0, err=0, all address/data outputs=0, FIFO empty, FSM=IDLE, hold counter=0.
REQ-028 cmd_ready SHALL be 1 and busy 0 while in reset; reset mid-SWAP SHALL drop swap immediately and discard queued commands.

Structure
REQ-029 A shared package swap_pkg SHALL hold the cmd_op encodings and FSM state typedef.
REQ-030 The command queue SHALL be a sub-module cmd_fifo (sync FIFO, parameterised width/depth); FSM and output registers live in swap_cmd_seq.

Verification
REQ-031 Ten back-to-back WRITEs addr/data 20..29 -> we high ten consecutive cycles, address_w=data_w=20..29 in order.
REQ-032 SWAP a=22 b=28 -> swap high exactly 3 cycles with address_A=22, address_B=28, then 1 low cycle, busy falls after.
REQ-033 SWAP 22/28 followed by WRITE 5/0xAA -> we for addr 5 first asserted 4 cycles after swap rises, never overlapping swap.
REQ-034 Six commands offered during a SWAP with FIFO_DEPTH=4 -> cmd_ready low after 4 accepted, remaining held, all executed in order.
REQ-035 SWAP a=b=10 and op 2'b11 -> err pulses once each, swap never asserted, queue continues.
REQ-036 reset_n low in second swap cycle -> swap=0 immediately, FIFO empty, cmd_ready=1, busy=0.
